// File: rtl/mcpu_ram_loader.sv
// RAM image loader: streams a program image into RAM, then reads every
// word back through the data and instruction ports and reports mismatches.
module mcpu_ram_loader #(
    parameter int WORD_SIZE  = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int LOAD_LEN   = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  s_valid,
    input  logic [WORD_SIZE-1:0]  s_data,
    output logic                  s_ready,
    output logic                  we,
    output logic [WORD_SIZE-1:0]  datawr,
    output logic                  re,
    output logic [ADDR_WIDTH-1:0] addr,
    input  logic [WORD_SIZE-1:0]  datard,
    output logic [ADDR_WIDTH-1:0] instraddr,
    input  logic [WORD_SIZE-1:0]  instrrd,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   err_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr
);

    // state     | meaning
    // IDLE      | waiting for start after reset
    // LOAD_WAIT | s_ready high, waiting for the next image word
    // WRITE     | one-cycle RAM write of the captured word
    // SETTLE    | one quiet cycle between the last write and read-back
    // VERIFY    | one address per cycle read back on both ports
    // DONE      | results held until the next start
    typedef enum logic [2:0] {
        IDLE,
        LOAD_WAIT,
        WRITE,
        SETTLE,
        VERIFY,
        DONE
    } state_t;

    localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH+1)'(LOAD_LEN - 1);
    localparam int SH_W = (LOAD_LEN > 1) ? $clog2(LOAD_LEN) : 1;

    state_t                state, next_state;
    logic [ADDR_WIDTH:0]   idx;
    logic [ADDR_WIDTH-1:0] idx_lo;
    logic [SH_W-1:0]       sh_idx;
    logic [WORD_SIZE-1:0]  wr_data;
    logic [WORD_SIZE-1:0]  shadow [2**SH_W];
    logic                  mismatch;

    assign idx_lo   = idx[ADDR_WIDTH-1:0];
    assign sh_idx   = idx[SH_W-1:0];
    assign mismatch = (datard != shadow[sh_idx]) || (instrrd != shadow[sh_idx]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx            <= '0;
            wr_data        <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        idx            <= '0;
                        err_count      <= '0;
                        first_err_addr <= '0;
                    end
                end
                LOAD_WAIT: if (s_valid) wr_data <= s_data;
                WRITE:     idx <= idx + 1'b1;
                SETTLE:    idx <= '0;
                VERIFY: begin
                    if (mismatch) begin
                        err_count <= err_count + 1'b1;
                        if (err_count == '0) first_err_addr <= idx_lo;
                    end
                    idx <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Shadow image has no reset; it is always rewritten before being read.
    always_ff @(posedge clk) begin
        if (state == WRITE) shadow[sh_idx] <= wr_data;
    end

    always_comb begin
        next_state = state;
        s_ready    = 1'b0;
        we         = 1'b0;
        re         = 1'b0;
        datawr     = '0;
        addr       = '0;
        instraddr  = '0;
        busy       = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        case (state)
            IDLE: if (start) next_state = LOAD_WAIT;
            LOAD_WAIT: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (s_valid) next_state = WRITE;
            end
            WRITE: begin
                we         = 1'b1;
                datawr     = wr_data;
                addr       = idx_lo;
                busy       = 1'b1;
                next_state = (idx == LAST_IDX) ? SETTLE : LOAD_WAIT;
            end
            SETTLE: begin
                busy       = 1'b1;
                next_state = VERIFY;
            end
            VERIFY: begin
                re        = 1'b1;
                addr      = idx_lo;
                instraddr = idx_lo;
                busy      = 1'b1;
                if (idx == LAST_IDX) next_state = DONE;
            end
            DONE: begin
                done  = 1'b1;
                error = (err_count != '0);
                if (start) next_state = LOAD_WAIT;
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mcpu_ram_loader.sv
// Bench for mcpu_ram_loader: random images against a RAM model with fault
// injection, compared each cycle against a transaction-level expectation.
module tb_mcpu_ram_loader;

    localparam int N = 256;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_ready, we, re, busy, done, error;
    logic [7:0] datawr, addr, datard, instraddr, instrrd, first_err_addr;
    logic [8:0] err_count;

    logic       start4 = 1'b0;
    logic       s_valid4 = 1'b0;
    logic [7:0] s_data4 = 8'h00;
    logic       s_ready4, we4, re4, busy4, done4, error4;
    logic [7:0] datawr4, addr4, datard4, instraddr4, instrrd4, first_err_addr4;
    logic [8:0] err_count4;

    logic [7:0] ram  [256];
    logic [7:0] ram4 [256];
    logic [7:0] img  [256];

    logic       fd_en = 1'b0, fi_en = 1'b0;
    logic [7:0] fd_addr = 8'h00, fi_addr = 8'h00, fd_val = 8'h00, fi_val = 8'h00;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    int wr_k, rd_k, c0, exp_lat, exp_err, exp_first, last_lat;
    logic done_q = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (we)  ram[addr]   <= datawr;
    always @(posedge clk) if (we4) ram4[addr4] <= datawr4;

    assign datard  = re ? ((fd_en && addr == fd_addr) ? fd_val : ram[addr]) : 8'h00;
    assign instrrd = (fi_en && instraddr == fi_addr) ? fi_val : ram[instraddr];
    assign datard4  = re4 ? ram4[addr4] : 8'h00;
    assign instrrd4 = ram4[instraddr4];

    mcpu_ram_loader #(.WORD_SIZE(8), .ADDR_WIDTH(8), .LOAD_LEN(N)) dut (
        .clk(clk), .reset(reset), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .we(we), .datawr(datawr), .re(re), .addr(addr),
        .datard(datard), .instraddr(instraddr), .instrrd(instrrd), .busy(busy),
        .done(done), .error(error), .err_count(err_count), .first_err_addr(first_err_addr)
    );

    mcpu_ram_loader #(.WORD_SIZE(8), .ADDR_WIDTH(8), .LOAD_LEN(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .s_valid(s_valid4), .s_data(s_data4),
        .s_ready(s_ready4), .we(we4), .datawr(datawr4), .re(re4), .addr(addr4),
        .datard(datard4), .instraddr(instraddr4), .instrrd(instrrd4), .busy(busy4),
        .done(done4), .error(error4), .err_count(err_count4), .first_err_addr(first_err_addr4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected result of a verify pass: what each port will return per address
    // versus the image that was streamed in.
    task automatic compute_model();
        logic [7:0] dv, iv;
        exp_err   = 0;
        exp_first = 0;
        for (int a = 0; a < N; a++) begin
            dv = (fd_en && 8'(a) == fd_addr) ? fd_val : img[8'(a)];
            iv = (fi_en && 8'(a) == fi_addr) ? fi_val : img[8'(a)];
            if (dv != img[8'(a)] || iv != img[8'(a)]) begin
                if (exp_err == 0) exp_first = a;
                exp_err++;
            end
        end
    endtask

    task automatic monitor_cycle();
        chk("we_re_exclusive", 32'(we & re), 32'd0);
        chk("ready_implies_busy", 32'(s_ready & ~busy), 32'd0);
        chk("busy_done_exclusive", 32'(busy & done), 32'd0);
        chk("error_flag", 32'(error), 32'(done && exp_err != 0));
        if (we) begin
            chk("write_addr", 32'(addr), 32'(wr_k));
            if (wr_k < N) chk("write_data", 32'(datawr), 32'(img[8'(wr_k)]));
            else          chk("write_count_overrun", 32'(wr_k), 32'(N - 1));
            wr_k++;
        end else begin
            chk("datawr_idle", 32'(datawr), 32'd0);
        end
        if (re) begin
            if (rd_k == 0) chk("all_written_before_verify", 32'(wr_k), 32'(N));
            chk("read_addr", 32'(addr), 32'(rd_k));
            chk("read_instraddr", 32'(instraddr), 32'(rd_k));
            rd_k++;
        end
        if (!we && !re) begin
            chk("addr_idle", 32'(addr), 32'd0);
            chk("instraddr_idle", 32'(instraddr), 32'd0);
        end
        if (done) begin
            chk("err_count", 32'(err_count), 32'(exp_err));
            chk("first_err_addr", 32'(first_err_addr), 32'(exp_first));
        end
        if (done && !done_q) begin
            last_lat = cyc - c0;
            chk("done_latency", 32'(last_lat), 32'(exp_lat));
            chk("verify_count", 32'(rd_k), 32'(N));
        end
        done_q = done;
    endtask

    task automatic run_main(input int stall_max, input bit busy_start, input bit check_clear);
        int st, sum, guard;
        sum = 0;
        exp_lat = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        c0   = cyc;
        wr_k = 0;
        rd_k = 0;
        compute_model();
        if (check_clear) begin
            chk("restart_done_low", 32'(done), 32'd0);
            chk("restart_s_ready", 32'(s_ready), 32'd1);
            chk("restart_err_count", 32'(err_count), 32'd0);
            chk("restart_first_err", 32'(first_err_addr), 32'd0);
        end
        for (int k = 0; k < N; k++) begin
            guard = 0;
            while (!s_ready && guard < 8) begin
                step();
                guard++;
            end
            if (!s_ready) chk("s_ready_timeout", 32'(s_ready), 32'd1);
            st = (stall_max == 0) ? 0 : int'($urandom_range(stall_max, 0));
            sum += st;
            repeat (st) step();
            if (busy_start && k == 3) start = 1'b1;
            s_valid = 1'b1;
            s_data  = img[8'(k)];
            step();
            s_valid = 1'b0;
            start   = 1'b0;
        end
        exp_lat = 3 * N + 1 + sum;
        guard = 0;
        while (!done && guard < N + 20) begin
            step();
            guard++;
        end
        if (!done) chk("done_timeout", 32'(done), 32'd1);
        step();
    endtask

    task automatic new_image();
        for (int a = 0; a < N; a++) img[8'(a)] = 8'($urandom);
    endtask

    task automatic check_ram(input string name);
        for (int a = 0; a < N; a++) chk(name, 32'(ram[8'(a)]), 32'(img[8'(a)]));
    endtask

    task automatic run_stalled4();
        logic [7:0] v [4];
        int guard;
        v[0] = 8'h11; v[1] = 8'h22; v[2] = 8'h33; v[3] = 8'h44;
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        c0 = cyc;
        for (int k = 0; k < 4; k++) begin
            guard = 0;
            while (!s_ready4 && guard < 8) begin
                step();
                guard++;
            end
            if (!s_ready4) chk("s_ready4_timeout", 32'(s_ready4), 32'd1);
            repeat (3) step();
            s_valid4 = 1'b1;
            s_data4  = v[k];
            step();
            s_valid4 = 1'b0;
        end
        guard = 0;
        while (!done4 && guard < 40) begin
            chk("we4_re4_exclusive", 32'(we4 & re4), 32'd0);
            step();
            guard++;
        end
        if (!done4) chk("done4_timeout", 32'(done4), 32'd1);
        chk("stalled_latency", 32'(cyc - c0), 32'd25);
        chk("stalled_error", 32'(error4), 32'd0);
        chk("stalled_err_count", 32'(err_count4), 32'd0);
        for (int a = 0; a < 4; a++) chk("stalled_ram", 32'(ram4[8'(a)]), 32'(v[a]));
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_s_ready"}, 32'(s_ready), 32'd0);
        chk({name, "_we"}, 32'(we), 32'd0);
        chk({name, "_datawr"}, 32'(datawr), 32'd0);
        chk({name, "_re"}, 32'(re), 32'd0);
        chk({name, "_addr"}, 32'(addr), 32'd0);
        chk({name, "_instraddr"}, 32'(instraddr), 32'd0);
        chk({name, "_busy"}, 32'(busy), 32'd0);
        chk({name, "_done"}, 32'(done), 32'd0);
        chk({name, "_error"}, 32'(error), 32'd0);
        chk({name, "_err_count"}, 32'(err_count), 32'd0);
        chk({name, "_first_err"}, 32'(first_err_addr), 32'd0);
        chk({name, "_busy4"}, 32'(busy4), 32'd0);
        chk({name, "_done4"}, 32'(done4), 32'd0);
    endtask

    initial begin
        int guard;
        exp_err = 0; exp_first = 0; exp_lat = 0; c0 = 0; wr_k = 0; rd_k = 0; last_lat = 0;
        repeat (2) step();
        check_all_zero("reset");
        reset = 1'b0;
        step();

        fork
            forever begin
                @(negedge clk);
                if (!reset) monitor_cycle();
            end
        join_none

        // Clean full load, s_valid always high.
        new_image();
        run_main(0, 1'b0, 1'b0);
        chk("full_latency_769", 32'(last_lat), 32'd769);
        chk("full_error", 32'(error), 32'd0);
        chk("full_err_count", 32'(err_count), 32'd0);
        check_ram("full_ram");

        // Data port bad at 0x05, instruction port bad at 0x09; start pulsed while busy.
        new_image();
        if (img[5] == 8'hFF) img[5] = 8'h00;
        if (img[9] == 8'h00) img[9] = 8'h01;
        fd_en = 1'b1; fd_addr = 8'h05; fd_val = 8'hFF;
        fi_en = 1'b1; fi_addr = 8'h09; fi_val = 8'h00;
        run_main(0, 1'b1, 1'b0);
        chk("fault_latency_769", 32'(last_lat), 32'd769);
        chk("fault_error", 32'(error), 32'd1);
        chk("fault_err_count", 32'(err_count), 32'd2);
        chk("fault_first_err", 32'(first_err_addr), 32'h05);

        // Restart from DONE with random stalls and no faults.
        fd_en = 1'b0; fi_en = 1'b0;
        new_image();
        run_main(2, 1'b0, 1'b1);
        chk("restart_error", 32'(error), 32'd0);
        chk("restart_final_err_count", 32'(err_count), 32'd0);
        check_ram("restart_ram");

        // Both ports wrong at the same address.
        new_image();
        fd_en = 1'b1; fd_addr = 8'h07; fd_val = img[7] ^ 8'h5A;
        fi_en = 1'b1; fi_addr = 8'h07; fi_val = img[7] ^ 8'hA5;
        run_main(1, 1'b0, 1'b1);
        chk("both_error", 32'(error), 32'd1);
        chk("both_err_count", 32'(err_count), 32'd1);
        chk("both_first_err", 32'(first_err_addr), 32'h07);
        fd_en = 1'b0; fi_en = 1'b0;

        // Asynchronous reset in the middle of a WRITE cycle.
        start = 1'b1;
        step();
        start = 1'b0;
        wr_k = 0; rd_k = 0; exp_err = 0; exp_first = 0;
        s_valid = 1'b1;
        s_data  = img[0];
        guard = 0;
        while (!we && guard < 8) begin
            step();
            guard++;
        end
        chk("reach_write", 32'(we), 32'd1);
        reset = 1'b1;
        #1;
        chk("async_we", 32'(we), 32'd0);
        chk("async_re", 32'(re), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_done", 32'(done), 32'd0);
        s_valid = 1'b0;
        repeat (2) step();
        reset = 1'b0;
        step();
        check_all_zero("post_reset");
        repeat (3) step();
        chk("stays_idle", 32'(busy), 32'd0);

        run_stalled4();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
